// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing the single write port of the 8 x 8 FIFO
//   among NUM_REQ producers. One producer is granted at a time for a burst
//   of up to MAX_BURST beats; its beats are forwarded to the FIFO write
//   port, and the burst stalls while the FIFO is full.
//
// Ports
//   clk            write-side clock, rising edge
//   reset          asynchronous reset, active low
//   req_valid      per-producer beat valid
//   req_data       producer i beat at [i*DATA_W +: DATA_W]
//   req_ready      per-producer accept (one-hot or zero)
//   fifo_full      FIFO full flag
//   fifo_write_en  FIFO write strobe
//   fifo_data      FIFO write data (zero when not writing)
//   grant_id       current or most recently granted producer
//   busy           high while a grant is active
//
// state | meaning
// IDLE  | no grant; picks the next producer round-robin after last_ptr
// GRANT | forwarding beats of producer grant_id
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic [CNT_W-1:0] beat_cnt;
  logic             transfer;
  logic             release_grant;

  // Scan from the farthest candidate back to last_ptr+1 so the nearest
  // set bit after last_ptr is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[(int'(last_ptr) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(last_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    transfer      = 1'b0;
    release_grant = 1'b0;
    fifo_write_en = 1'b0;
    fifo_data     = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) state_nxt = GRANT;
      end
      GRANT: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        transfer            = req_valid[grant_id] && !fifo_full;
        fifo_write_en       = transfer;
        if (transfer) fifo_data = req_data[int'(grant_id)*DATA_W +: DATA_W];
        // A producer that drops valid gives up the rest of its burst.
        release_grant = !req_valid[grant_id] || (transfer && beat_cnt == LAST_BEAT);
        if (release_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= '0;
      last_ptr <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_found) begin
        grant_id <= win_id;
        beat_cnt <= '0;
      end
      if (release_grant) begin
        last_ptr <= grant_id;
        beat_cnt <= '0;
      end else if (transfer) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Producer data advances by one on every accepted beat.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic       s_busy, s_wr;
  logic [7:0] s_data;
  logic [3:0] s_rdy;
  logic [1:0] s_gid;
  int         wr_cnt;
  logic       model_en;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data     (fifo_data),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_busy = busy;
    s_wr   = fifo_write_en;
    s_data = fifo_data;
    s_rdy  = req_ready;
    s_gid  = grant_id;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && s_rdy[i]) req_data[i*8 +: 8] = req_data[i*8 +: 8] + 8'd1;
    if (s_wr) wr_cnt++;
    if (model_en) fifo_full = (wr_cnt >= 8);
  endtask

  task automatic chk_cycle(input string tag, input logic e_busy, input logic e_wr,
                           input logic [7:0] e_data, input logic [3:0] e_rdy);
    chk({tag, " busy"},  32'(s_busy), 32'(e_busy));
    chk({tag, " wr"},    32'(s_wr),   32'(e_wr));
    chk({tag, " data"},  32'(s_data), 32'(e_data));
    chk({tag, " ready"}, 32'(s_rdy),  32'(e_rdy));
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    model_en  = 1'b0;
    wr_cnt    = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [3:0] t3_full  [9] = '{0,0,0,1,1,1,0,0,0};
  logic [3:0] t3_busy  [9] = '{0,1,1,1,1,1,1,1,0};
  logic [3:0] t3_wr    [9] = '{0,1,1,0,0,0,1,1,0};
  logic [7:0] t3_data  [9] = '{8'h00,8'h30,8'h31,8'h00,8'h00,8'h00,8'h32,8'h33,8'h00};
  logic [3:0] t3_rdy   [9] = '{0,4,4,0,0,0,4,4,0};

  logic [3:0] t4_valid [11] = '{4'b1010,4'b1010,4'b1010,4'b1001,4'b1001,4'b1001,
                                4'b1001,4'b1001,4'b1001,4'b1001,4'b1001};
  logic [3:0] t4_busy  [11] = '{0,1,1,1,0,1,1,1,1,0,1};
  logic [3:0] t4_wr    [11] = '{0,1,1,0,0,1,1,1,1,0,1};
  logic [7:0] t4_data  [11] = '{8'h00,8'h40,8'h41,8'h00,8'h00,8'h60,8'h61,8'h62,8'h63,8'h00,8'h50};
  logic [3:0] t4_rdy   [11] = '{0,2,2,2,0,8,8,8,8,0,1};
  logic [1:0] t4_gid   [11] = '{0,1,1,1,1,3,3,3,3,3,0};

  logic [7:0] t1_data  [7]  = '{8'h00,8'h11,8'h12,8'h13,8'h14,8'h00,8'h15};

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_en  = 1'b0;
    wr_cnt    = 0;
    #3;
    chk("rst busy",  32'(busy),          32'd0);
    chk("rst ready", 32'(req_ready),     32'd0);
    chk("rst wr",    32'(fifo_write_en), 32'd0);
    chk("rst data",  32'(fifo_data),     32'd0);
    chk("rst gid",   32'(grant_id),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: producer 0 alone, full burst, bubble, re-grant.
    req_data[7:0] = 8'h11;
    req_valid     = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk_cycle($sformatf("t1 c%0d", c), (c != 0 && c != 5), (c != 0 && c != 5),
                t1_data[c], (c != 0 && c != 5) ? 4'b0001 : 4'b0000);
      chk($sformatf("t1 gid c%0d", c), 32'(s_gid), 32'd0);
    end

    // 2: all producers valid; order 0,1,2,3,0 with a bubble before each grant.
    do_reset();
    req_data  = {8'h61, 8'h41, 8'h21, 8'h01};
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      int g, p, id;
      logic [7:0] base;
      g  = c / 5;
      p  = c % 5;
      id = g % 4;
      base = 8'h01 + 8'h20 * 8'(id);
      tick();
      if (p == 0) begin
        chk_cycle($sformatf("t2 c%0d", c), 1'b0, 1'b0, 8'h00, 4'b0000);
        chk($sformatf("t2 hold gid c%0d", c), 32'(s_gid), (g == 0) ? 32'd0 : 32'((g - 1) % 4));
      end else begin
        chk_cycle($sformatf("t2 c%0d", c), 1'b1, 1'b1,
                  base + 8'((g / 4) * 4 + p - 1), 4'(1 << id));
        chk($sformatf("t2 gid c%0d", c), 32'(s_gid), 32'(id));
      end
    end

    // 3: producer 2 alone, FIFO full for 3 cycles after its 2nd beat.
    do_reset();
    req_data[23:16] = 8'h30;
    req_valid       = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      fifo_full = t3_full[c][0];
      tick();
      chk_cycle($sformatf("t3 c%0d", c), t3_busy[c][0], t3_wr[c][0], t3_data[c], t3_rdy[c]);
    end

    // 4: producer 1 drops valid after 2 beats; 3 then 0 follow.
    do_reset();
    req_data[15:8]  = 8'h40;
    req_data[31:24] = 8'h60;
    req_data[7:0]   = 8'h50;
    for (int c = 0; c < 11; c++) begin
      req_valid = t4_valid[c];
      tick();
      chk_cycle($sformatf("t4 c%0d", c), t4_busy[c][0], t4_wr[c][0], t4_data[c], t4_rdy[c]);
      chk($sformatf("t4 gid c%0d", c), 32'(s_gid), 32'(t4_gid[c]));
    end

    // 5: reset in the middle of a burst, then 0 beats 2 again.
    do_reset();
    req_data[7:0]   = 8'h70;
    req_data[23:16] = 8'h80;
    req_valid       = 4'b0101;
    tick();
    chk_cycle("t5 idle", 1'b0, 1'b0, 8'h00, 4'b0000);
    tick();
    chk_cycle("t5 beat1", 1'b1, 1'b1, 8'h70, 4'b0001);
    reset = 1'b0;
    #2;
    chk("t5 async wr",    32'(fifo_write_en), 32'd0);
    chk("t5 async ready", 32'(req_ready),     32'd0);
    chk("t5 async busy",  32'(busy),          32'd0);
    tick();
    chk_cycle("t5 in reset", 1'b0, 1'b0, 8'h00, 4'b0000);
    reset = 1'b1;
    tick();
    chk_cycle("t5 after idle", 1'b0, 1'b0, 8'h00, 4'b0000);
    tick();
    chk_cycle("t5 regrant", 1'b1, 1'b1, 8'h71, 4'b0001);
    chk("t5 regrant gid", 32'(s_gid), 32'd0);

    // 6: fill the FIFO with 8 beats, never read; grant then holds forever.
    do_reset();
    model_en      = 1'b1;
    req_data[7:0] = 8'h90;
    req_valid     = 4'b0001;
    for (int c = 0; c < 11; c++) tick();
    chk("t6 writes", 32'(wr_cnt), 32'd8);
    chk("t6 full", 32'(fifo_full), 32'd1);
    chk("t6 next data", 32'(req_data[7:0]), 32'h98);
    for (int c = 11; c < 31; c++) begin
      tick();
      chk_cycle($sformatf("t6 stall c%0d", c), 1'b1, 1'b0, 8'h00, 4'b0000);
    end
    chk("t6 writes end", 32'(wr_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
